// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and default sizing for the PLL acquisition controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pll_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_TRACK  = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  localparam int PKG_FREQ_INIT = 1000;
  localparam int PKG_FREQ_MIN  = 10;
  localparam int PKG_FREQ_MAX  = 2000;
  localparam int PKG_CNT_W     = 12;

endpackage

// File: rtl/pll_acq_ctrl_edge_window_counter.sv
// Window timer plus two saturating edge counters; latches both counts at window end.
// Latency: latched counts and win_done appear the cycle after the terminal timer count.
// Backpressure: none; edge pulses are counted every cycle while run is high.
module edge_window_counter
  import pll_ctrl_pkg::*;
#(
  parameter int WIN_LOG2 = 16,
  parameter int CNT_W    = PKG_CNT_W
) (
  input  logic             clk_50,
  input  logic             rst,
  input  logic             run,
  input  logic             clr,
  input  logic             vco_edge,
  input  logic             fb_edge,
  output logic [CNT_W-1:0] vco_lat,
  output logic [CNT_W-1:0] fb_lat,
  output logic             win_done
);

  localparam logic [WIN_LOG2-1:0] TMR_LAST = '1;

  logic [WIN_LOG2-1:0] tmr;
  logic [CNT_W-1:0]    vco_cnt;
  logic [CNT_W-1:0]    fb_cnt;
  logic [CNT_W-1:0]    vco_nxt;
  logic [CNT_W-1:0]    fb_nxt;

  // Saturating increments, so the terminal-cycle edge is included in the latched value.
  always_comb begin
    vco_nxt = vco_cnt;
    fb_nxt  = fb_cnt;
    if (vco_edge && (vco_cnt != '1)) vco_nxt = vco_cnt + 1'b1;
    if (fb_edge && (fb_cnt != '1))   fb_nxt  = fb_cnt + 1'b1;
  end

  // Timer and counters; a stopped or cleared loop discards the partial window.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      tmr      <= '0;
      vco_cnt  <= '0;
      fb_cnt   <= '0;
      vco_lat  <= '0;
      fb_lat   <= '0;
      win_done <= 1'b0;
    end else if (!run || clr) begin
      tmr      <= '0;
      vco_cnt  <= '0;
      fb_cnt   <= '0;
      win_done <= 1'b0;
    end else begin
      win_done <= 1'b0;
      tmr      <= tmr + 1'b1;
      if (tmr == TMR_LAST) begin
        vco_lat  <= vco_nxt;
        fb_lat   <= fb_nxt;
        vco_cnt  <= '0;
        fb_cnt   <= '0;
        win_done <= 1'b1;
      end else begin
        vco_cnt <= vco_nxt;
        fb_cnt  <= fb_nxt;
      end
    end
  end

endmodule

// File: rtl/pll_acq_ctrl.sv
// PLL acquisition/lock sequencer: sweeps the VCO word until edge rates match, then tracks and qualifies lock.
// Latency: window end -> freq_ld / state change in 1 cycle; enable low -> IDLE next cycle.
// Backpressure: none. Optional PLL_LOSE_HYST_EN: LOCKED exits only after two consecutive bad windows.
module pll_acq_ctrl
  import pll_ctrl_pkg::*;
#(
  parameter int FREQ_W       = 11,
  parameter int FREQ_INIT    = PKG_FREQ_INIT,
  parameter int FREQ_MIN     = PKG_FREQ_MIN,
  parameter int FREQ_MAX     = PKG_FREQ_MAX,
  parameter int STEP         = 4,
  parameter int WIN_LOG2     = 16,
  parameter int CNT_W        = PKG_CNT_W,
  parameter int LOCK_WINDOWS = 8,
  parameter int LOSE_TOL     = 3
) (
  input  logic              clk_50,
  input  logic              rst,
  input  logic              enable,
  input  logic              vco_edge,
  input  logic              fb_edge,
  output logic [FREQ_W-1:0] freq_word,
  output logic              freq_ld,
  output logic              track_en,
  output logic              locked,
  output logic              lost,
  output logic [1:0]        state
);

  localparam logic [FREQ_W-1:0] WORD_INIT = FREQ_W'(FREQ_INIT);
  localparam logic [FREQ_W:0]   MAX_X     = (FREQ_W+1)'(FREQ_MAX);
  localparam logic [FREQ_W:0]   MIN_X     = (FREQ_W+1)'(FREQ_MIN);
  localparam logic [FREQ_W:0]   STEP_X    = (FREQ_W+1)'(STEP);
  localparam logic [CNT_W:0]    TOL_X     = (CNT_W+1)'(LOSE_TOL);
  localparam logic [CNT_W:0]    CLOSE_X   = (CNT_W+1)'(1);
  localparam int                GOOD_W    = $clog2(LOCK_WINDOWS + 1);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_WINDOWS - 1);

  state_t              st;
  logic [GOOD_W-1:0]   good_cnt;
  logic                run;
  logic                clr;
  logic                win_done;
  logic [CNT_W-1:0]    vco_lat;
  logic [CNT_W-1:0]    fb_lat;
  logic signed [CNT_W:0] diff;
  logic [CNT_W:0]      abs_diff;
  logic                close;
  logic                bad;
  logic                lock_exit;
  logic [FREQ_W:0]     word_x;
  logic [FREQ_W:0]     up_x;
  logic [FREQ_W-1:0]   dn_w;
  logic [FREQ_W-1:0]   next_word;

  assign state = st;

  // The window only runs while the loop is active; leaving LOCKED restarts it from zero.
  assign run = enable && (st != ST_IDLE);
  assign clr = lock_exit;

  edge_window_counter #(
    .WIN_LOG2 (WIN_LOG2),
    .CNT_W    (CNT_W)
  ) u_win (
    .clk_50   (clk_50),
    .rst      (rst),
    .run      (run),
    .clr      (clr),
    .vco_edge (vco_edge),
    .fb_edge  (fb_edge),
    .vco_lat  (vco_lat),
    .fb_lat   (fb_lat),
    .win_done (win_done)
  );

  // Positive diff means feedback runs faster than the VCO, so the word must go up.
  assign diff     = $signed({1'b0, fb_lat}) - $signed({1'b0, vco_lat});
  assign abs_diff = diff[CNT_W] ? $unsigned(-diff) : $unsigned(diff);
  assign close    = (abs_diff <= CLOSE_X);
  assign bad      = (abs_diff > TOL_X);

  assign word_x = {1'b0, freq_word};
  assign up_x   = word_x + STEP_X;
  assign dn_w   = freq_word - STEP_X[FREQ_W-1:0];

  // Next sweep word, clamped without wrap at either end.
  always_comb begin
    next_word = freq_word;
    if (!diff[CNT_W]) begin
      next_word = (up_x > MAX_X) ? MAX_X[FREQ_W-1:0] : up_x[FREQ_W-1:0];
    end else begin
      next_word = (word_x < (MIN_X + STEP_X)) ? MIN_X[FREQ_W-1:0] : dn_w;
    end
  end

`ifdef PLL_LOSE_HYST_EN
  logic bad_pend;
  assign lock_exit = enable && win_done && (st == ST_LOCKED) && bad && bad_pend;
`else
  assign lock_exit = enable && win_done && (st == ST_LOCKED) && bad;
`endif

  // Sequencer with registered outputs; evaluation happens on the win_done cycle.
  always_ff @(posedge clk_50 or posedge rst) begin
    if (rst) begin
      st        <= ST_IDLE;
      freq_word <= WORD_INIT;
      freq_ld   <= 1'b0;
      track_en  <= 1'b0;
      locked    <= 1'b0;
      lost      <= 1'b0;
      good_cnt  <= '0;
`ifdef PLL_LOSE_HYST_EN
      bad_pend  <= 1'b0;
`endif
    end else begin
      freq_ld <= 1'b0;
      lost    <= 1'b0;
      if (!enable) begin
        st       <= ST_IDLE;
        track_en <= 1'b0;
        locked   <= 1'b0;
        good_cnt <= '0;
`ifdef PLL_LOSE_HYST_EN
        bad_pend <= 1'b0;
`endif
      end else begin
        case (st)
          ST_IDLE: begin
            st        <= ST_SWEEP;
            freq_word <= WORD_INIT;
            freq_ld   <= 1'b1;
          end
          ST_SWEEP: begin
            if (win_done) begin
              if (close) begin
                st       <= ST_TRACK;
                track_en <= 1'b1;
                good_cnt <= '0;
              end else if (next_word != freq_word) begin
                freq_word <= next_word;
                freq_ld   <= 1'b1;
              end
            end
          end
          ST_TRACK: begin
            if (win_done) begin
              if (close) begin
                good_cnt <= good_cnt + 1'b1;
                if (good_cnt == GOOD_LAST) begin
                  st     <= ST_LOCKED;
                  locked <= 1'b1;
`ifdef PLL_LOSE_HYST_EN
                  bad_pend <= 1'b0;
`endif
                end
              end else begin
                good_cnt <= '0;
                if (bad) begin
                  st       <= ST_SWEEP;
                  track_en <= 1'b0;
                end
              end
            end
          end
          ST_LOCKED: begin
            if (lock_exit) begin
              st        <= ST_SWEEP;
              lost      <= 1'b1;
              locked    <= 1'b0;
              track_en  <= 1'b0;
              freq_word <= WORD_INIT;
              freq_ld   <= 1'b1;
`ifdef PLL_LOSE_HYST_EN
              bad_pend  <= 1'b0;
`endif
            end
`ifdef PLL_LOSE_HYST_EN
            else if (win_done) begin
              bad_pend <= bad;
            end
`endif
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pll_acq_ctrl.sv
// Self-checking bench for pll_acq_ctrl with a short window so many windows fit in the run.
// Latency: n/a.
// Backpressure: n/a.
module tb_pll_acq_ctrl;

  localparam int FREQ_W = 11;
  localparam int WLOG   = 6;
  localparam int CW     = 6;
  localparam int WIN    = 64;
  localparam int SAT    = 63;
  localparam int STEP   = 4;
  localparam int FINIT  = 1000;
  localparam int FMIN   = 10;
  localparam int FMAX   = 2000;
  localparam int LOCKW  = 8;
  localparam int TOL    = 3;

  logic clk_50 = 1'b0;
  logic rst = 1'b0;
  logic enable = 1'b0;
  logic vco_edge = 1'b0;
  logic fb_edge = 1'b0;
  logic [FREQ_W-1:0] freq_word;
  logic freq_ld, track_en, locked, lost;
  logic [1:0] state;

  int errors = 0;
  int checks = 0;
  int tcyc = 0;
  int vp = 0;
  int fp = 0;

  always #5 clk_50 = ~clk_50;

  pll_acq_ctrl #(
    .FREQ_W(FREQ_W), .FREQ_INIT(FINIT), .FREQ_MIN(FMIN), .FREQ_MAX(FMAX), .STEP(STEP),
    .WIN_LOG2(WLOG), .CNT_W(CW), .LOCK_WINDOWS(LOCKW), .LOSE_TOL(TOL)
  ) dut (
    .clk_50(clk_50), .rst(rst), .enable(enable), .vco_edge(vco_edge), .fb_edge(fb_edge),
    .freq_word(freq_word), .freq_ld(freq_ld), .track_en(track_en), .locked(locked),
    .lost(lost), .state(state)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks position inside the current window, running counts and the last latched pair.
  int m_st, m_word, m_ld, m_trk, m_lck, m_lost;
  int m_wpos, m_cv, m_cf, m_lv, m_lf, m_pend, m_good, m_badp;

  task automatic model_reset();
    m_st = 0; m_word = FINIT; m_ld = 0; m_trk = 0; m_lck = 0; m_lost = 0;
    m_wpos = 0; m_cv = 0; m_cf = 0; m_lv = 0; m_lf = 0; m_pend = 0; m_good = 0; m_badp = 0;
  endtask

  task automatic model_step();
    int ev, d, ad, nw, is_bad;
    m_ld = 0;
    m_lost = 0;
    if (!enable) begin
      m_st = 0; m_trk = 0; m_lck = 0; m_wpos = 0; m_cv = 0; m_cf = 0;
      m_pend = 0; m_good = 0; m_badp = 0;
      return;
    end
    ev = m_pend;
    d  = m_lf - m_lv;
    ad = (d < 0) ? -d : d;
    m_pend = 0;
    if (m_st != 0) begin
      m_cv = (m_cv + int'(vco_edge) > SAT) ? SAT : m_cv + int'(vco_edge);
      m_cf = (m_cf + int'(fb_edge) > SAT) ? SAT : m_cf + int'(fb_edge);
      if (m_wpos == WIN - 1) begin
        m_lv = m_cv; m_lf = m_cf; m_cv = 0; m_cf = 0; m_wpos = 0; m_pend = 1;
      end else begin
        m_wpos++;
      end
    end
    case (m_st)
      0: begin m_st = 1; m_word = FINIT; m_ld = 1; end
      1: if (ev != 0) begin
           if (ad <= 1) begin
             m_st = 2; m_trk = 1; m_good = 0;
           end else begin
             nw = (d > 0) ? m_word + STEP : m_word - STEP;
             if (nw > FMAX) nw = FMAX;
             if (nw < FMIN) nw = FMIN;
             if (nw != m_word) begin m_word = nw; m_ld = 1; end
           end
         end
      2: if (ev != 0) begin
           if (ad <= 1) begin
             m_good++;
             if (m_good == LOCKW) begin m_st = 3; m_lck = 1; m_badp = 0; end
           end else begin
             m_good = 0;
             if (ad > TOL) begin m_st = 1; m_trk = 0; end
           end
         end
      default: if (ev != 0) begin
           is_bad = (ad > TOL);
`ifdef PLL_LOSE_HYST_EN
           if (is_bad != 0 && m_badp == 0) begin m_badp = 1; is_bad = 0; end
           else if (is_bad == 0) m_badp = 0;
`endif
           if (is_bad != 0) begin
             m_st = 1; m_lost = 1; m_lck = 0; m_trk = 0; m_word = FINIT; m_ld = 1;
             m_wpos = 0; m_cv = 0; m_cf = 0; m_pend = 0; m_badp = 0;
           end
         end
    endcase
  endtask

  always @(posedge clk_50 or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk_50) begin
    check("state", int'(state), m_st);
    check("freq_word", int'(freq_word), m_word);
    check("freq_ld", int'(freq_ld), m_ld);
    check("track_en", int'(track_en), m_trk);
    check("locked", int'(locked), m_lck);
    check("lost", int'(lost), m_lost);
  end

  // ---------------- stimulus helpers ----------------
  // Mode p: >0 periodic pulse every p cycles, 0 silent, <0 random with -p percent probability.
  function automatic logic gen(input int p);
    if (p > 0) return (tcyc % p) == 0;
    if (p < 0) return int'($urandom_range(99)) < -p;
    return 1'b0;
  endfunction

  task automatic drive_cycle();
    @(negedge clk_50);
    tcyc++;
    vco_edge = gen(vp);
    fb_edge  = gen(fp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) drive_cycle();
  endtask

  task automatic wait_state(input int target, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      drive_cycle();
      if (int'(state) == target) begin
        n = i;
        return;
      end
    end
  endtask

  task automatic do_rst();
    drive_cycle();
    #2 rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
  endtask

  function automatic int pick_mode();
    case ($urandom_range(3))
      0: return 0;
      1: return int'($urandom_range(2, 9));
      2: return -int'($urandom_range(5, 95));
      default: return 1;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin
    int q[$];
    int n, cnt, found;
    #1 rst = 1'b1;
    cycles(3);
    check("rst_state", int'(state), 0);
    check("rst_word", int'(freq_word), 1000);
    check("rst_ld", int'(freq_ld), 0);
    check("rst_track", int'(track_en), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_lost", int'(lost), 0);

    // Feedback at twice the VCO rate: word climbs by STEP each window.
    vp = 8; fp = 4; enable = 1'b1; rst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      drive_cycle();
      if (freq_ld) q.push_back(int'(freq_word));
    end
    check("sweep_ld_count", q.size(), 5);
    for (int i = 0; i < q.size() && i < 5; i++) check("sweep_word_seq", q[i], 1000 + 4 * i);
    check("sweep_state", int'(state), 1);

    // Matched rates: TRACK, then LOCKED after LOCK_WINDOWS good windows.
    vp = 4; fp = 4;
    wait_state(2, 300, n);
    check("reach_track", int'(n > 0), 1);
    check("track_en_in_track", int'(track_en), 1);
    wait_state(3, 700, n);
    check("track_to_lock_cycles", n, 512);
    check("lock_locked", int'(locked), 1);
    check("lock_track_en", int'(track_en), 1);

    // Feedback stalls: exactly one loss event, back to SWEEP with the reset word.
    fp = 0;
    cnt = 0;
    for (int i = 0; i < 428; i++) begin
      if (i == 128) fp = 4;
      drive_cycle();
      if (lost) begin
        cnt++;
        check("lost_state", int'(state), 1);
        check("lost_word", int'(freq_word), 1000);
        check("lost_locked", int'(locked), 0);
        check("lost_ld", int'(freq_ld), 1);
      end
    end
    check("lost_pulses", cnt, 1);

    // Downward clamp at FREQ_MIN, then no further loads.
    enable = 1'b0; cycles(2); enable = 1'b1;
    vp = 4; fp = 0;
    cycles(260 * WIN);
    check("clamp_min_word", int'(freq_word), 10);
    cnt = 0;
    for (int i = 0; i < 3 * WIN; i++) begin drive_cycle(); cnt += int'(freq_ld); end
    check("clamp_min_no_ld", cnt, 0);

    // Upward clamp at FREQ_MAX.
    enable = 1'b0; cycles(2); enable = 1'b1;
    vp = 8; fp = 2;
    cycles(260 * WIN);
    check("clamp_max_word", int'(freq_word), 2000);
    cnt = 0;
    for (int i = 0; i < 3 * WIN; i++) begin drive_cycle(); cnt += int'(freq_ld); end
    check("clamp_max_no_ld", cnt, 0);

    // Edges on the terminal window cycle land in the ending window.
    vp = 0; fp = 0;
    do_rst();
    enable = 1'b1;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      drive_cycle();
      if (m_st == 1 && m_wpos == WIN - 1) begin
        vco_edge = 1'b1; fb_edge = 1'b1; found = 1;
        break;
      end
    end
    check("term_found", found, 1);
    drive_cycle();
    check("term_vco_lat", int'(dut.u_win.vco_lat), 1);
    check("term_fb_lat", int'(dut.u_win.fb_lat), 1);
    check("term_vco_restart", int'(dut.u_win.vco_cnt), 0);
    check("term_fb_restart", int'(dut.u_win.fb_cnt), 0);
    check("term_win_done", int'(dut.u_win.win_done), 1);
    drive_cycle();
    check("term_to_track", int'(state), 2);

    // enable dropped mid-window in TRACK.
    cycles(20);
    check("pre_drop_track", int'(state), 2);
    enable = 1'b0;
    drive_cycle();
    check("drop_state", int'(state), 0);
    check("drop_track_en", int'(track_en), 0);
    check("drop_locked", int'(locked), 0);
    check("drop_ld", int'(freq_ld), 0);
    enable = 1'b1;
    drive_cycle();
    check("reenable_ld", int'(freq_ld), 1);

    // Asynchronous reset in TRACK takes effect immediately.
    wait_state(2, 300, n);
    check("reach_track2", int'(n > 0), 1);
    cycles(30);
    #2 rst = 1'b1;
    #1;
    check("arst_state", int'(state), 0);
    check("arst_track_en", int'(track_en), 0);
    check("arst_word", int'(freq_word), 1000);
    check("arst_ld", int'(freq_ld), 0);
    drive_cycle();
    rst = 1'b0;

    // Randomized segments, checked every cycle against the model.
    for (int s = 0; s < 40; s++) begin
      int r;
      r  = int'($urandom_range(9));
      vp = pick_mode();
      fp = ($urandom_range(1) == 1) ? vp : pick_mode();
      if (r == 0) begin
        enable = 1'b0;
        cycles(int'($urandom_range(1, 5)));
        enable = 1'b1;
      end else if (r == 1) begin
        do_rst();
      end
      cycles(int'($urandom_range(64, 600)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pll_acq_ctrl.md
Name: pll_acq_ctrl

Overview:
- Acquisition and lock sequencer for the 50 MHz software PLL, i.e. the phase-accumulator VCO plus phase comparator.
- Measures the VCO and feedback edge rates over fixed windows and steps the VCO frequency word until the two rates match.
- Then hands control to the phase comparator's slew path (track_en) and qualifies lock.
- Sits between the phase comparator/edge detectors and the VCO frequency register; drives the lock LED and display status.

Parameters:
- FREQ_W, 11: width of the VCO frequency word.
- FREQ_INIT, 1000: frequency word loaded on reset and on entry to SWEEP.
- FREQ_MIN, 10: lower clamp for freq_word.
- FREQ_MAX, 2000: upper clamp for freq_word.
- STEP, 4: freq_word increment/decrement per SWEEP window.
- WIN_LOG2, 16: measurement window = 2^WIN_LOG2 clk_50 cycles.
- CNT_W, 12: edge-counter width; counters saturate at 2^CNT_W-1.
- LOCK_WINDOWS, 8: consecutive good windows in TRACK needed to declare lock.
- LOSE_TOL, 3: |diff| above this in LOCKED counts as a bad window.

Ports:
- clk_50, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: run the loop; low forces IDLE.
- vco_edge, in, 1: single-cycle pulse on each VCO rising edge.
- fb_edge, in, 1: single-cycle pulse on each synchronised feedback rising edge.
- freq_word, out, FREQ_W: frequency word driven to the VCO.
- freq_ld, out, 1: one-cycle strobe; VCO loads freq_word.
- track_en, out, 1: gates phase-comparator slew_fast/slew_slow into the VCO.
- locked, out, 1: lock indicator.
- lost, out, 1: one-cycle pulse on LOCKED->SWEEP.
- state, out, 2: current state, for LEDs/debug.

Behaviour:
- Reset (async, immediate): state=IDLE, freq_word=FREQ_INIT, freq_ld=0, track_en=0, locked=0, lost=0; window timer, counters and good-window count all cleared.
- States: IDLE=0, SWEEP=1, TRACK=2, LOCKED=3. enable=0 in any state -> IDLE next cycle; freq_word is held, track_en=0, locked=0.
- IDLE -> SWEEP when enable=1. On entry to SWEEP from IDLE or LOCKED: freq_word<=FREQ_INIT, freq_ld=1 for 1 cycle, window timer and counters cleared.
- Window: timer counts 0..2^WIN_LOG2-1. Each vco_edge/fb_edge increments its own counter, saturating.
- At the terminal timer count, the window ends: both counts are latched, including any edge on that same cycle; counters restart from 0; the next cycle's edges go to the new window.
- Evaluation happens one cycle after window end, using diff = fb_cnt - vco_cnt (signed, CNT_W+1 bits).
  - SWEEP: if |diff|<=1 -> TRACK with track_en=1 and good count=0. Else freq_word +=STEP if diff>0, -=STEP if diff<0, clamped to [FREQ_MIN,FREQ_MAX] with no wrap; freq_ld pulses on that cycle. If the clamped value equals the current word, freq_ld stays 0.
  - TRACK: |diff|<=1 -> good count +1; reaching LOCK_WINDOWS -> LOCKED. Otherwise good count=0; |diff|>LOSE_TOL -> SWEEP without reloading freq_word, track_en=0.
  - LOCKED: locked=1, track_en=1. A window with |diff|>LOSE_TOL -> SWEEP, lost=1 for 1 cycle, locked=0 the same cycle.
- freq_word never changes in TRACK/LOCKED; the VCO's own slew path does fine correction there.
- Simultaneous vco_edge and fb_edge: both counted.
- enable deasserted mid-window: window discarded, no evaluation.
- Latency: window end -> freq_ld or state change = 1 cycle.

Optional Feature:
- Macro: PLL_LOSE_HYST_EN.
- Defined: LOCKED exits only after 2 consecutive bad windows; a single good window clears the pending-bad flag.
- Undefined: a single bad window exits LOCKED.

Decomposition:
- pll_ctrl_pkg holds:
  - state encoding constants ST_IDLE/ST_SWEEP/ST_TRACK/ST_LOCKED;
  - default FREQ_INIT/MIN/MAX;
  - CNT_W.
- Sub-module edge_window_counter contains the window timer, the two saturating edge counters, the latched counts and a win_done strobe. The FSM and clamp arithmetic stay in pll_acq_ctrl.

Test Plan:
- Reset held, then released with enable=1 and fb at 2x VCO rate -> freq_word 1000->1004->1008… each window; freq_ld pulses once per window.
- FB rate matching freq_word=1000 (|diff|<=1) -> SWEEP->TRACK after 1 window, LOCKED after 8 more; locked=1, track_en=1.
- In LOCKED, stop fb_edge for one window (diff=-N) -> lost pulse, SWEEP, freq_word=1000. With PLL_LOSE_HYST_EN, 2 bad windows are required.
- fb far below FREQ_MIN -> freq_word walks down and clamps at 10; freq_ld stops once clamped.
- vco_edge and fb_edge asserted on the terminal window cycle -> both counted in the ending window; the new window's counts start at 0.
- rst pulse or enable=0 mid-window in TRACK -> IDLE immediately/next cycle, track_en=0, locked=0, no freq_ld.
